// File: rtl/mem_data_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_data_if
// Purpose  : Memory-side source for the datapath bus. Holds MAR and MDR and
//            runs single-word read/write transactions to data memory over a
//            req/ack handshake, with an optional request timeout.
// Ports    : clock, reset_n          - clock, async active-low reset
//            BusMuxOut, MARin, MDRin - bus value and register load strobes
//            rd_start, wr_start      - one-cycle transaction start pulses
//            mem_req/we/addr/wdata   - request side of the memory handshake
//            mem_rdata, mem_ack      - response side of the memory handshake
//            mdr_q                   - MDR contents for the bus mux
//            busy, done, err         - transaction status
// Revision : 1.0 - initial release
// ============================================================================
module mem_data_if #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_REQ = 2'd1,
    S_WR_REQ = 2'd2,
    S_DONE   = 2'd3
  } memState_t;

  // Count value seen at the edge that ends the TIMEOUT-th request cycle.
  localparam logic [CNT_W-1:0] c_LAST_COUNT = CNT_W'(TIMEOUT - 1);

  memState_t         r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [31:0]       r_mdr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic              w_timeoutHit;

  assign w_timeoutHit = (TIMEOUT != 0) && (r_count == c_LAST_COUNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Loads land in the same edge as a start, so the transaction
          // uses the freshly loaded MAR/MDR.
          if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) r_mdr <= BusMuxOut;
          r_err <= 1'b0;
          if (rd_start) begin
            r_state <= S_RD_REQ;
            r_count <= '0;
          end else if (wr_start) begin
            r_state <= S_WR_REQ;
            r_count <= '0;
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          // Ack takes precedence over a coincident timeout.
          if (mem_ack) begin
            if (r_state == S_RD_REQ) r_mdr <= mem_rdata;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeoutHit) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs decode directly from registers, so reset reaches them
  // without waiting for a clock edge.
  assign mem_req   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign mem_we    = (r_state == S_WR_REQ);
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign mdr_q     = r_mdr;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_data_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_data_if
// Purpose  : Directed self-checking bench for mem_data_if.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_data_if;

  logic        clock;
  logic        reset_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, rd_start, wr_start;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, mdr_q;
  logic        mem_ack, busy, done, err;

  int passCount  = 0;
  int checkCount = 0;
  int cycles;

  mem_data_if #(.ADDR_W(9), .TIMEOUT(16), .CNT_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mdr_q     (mdr_q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      passCount++;
  endtask

  // Advance past one rising edge; outputs are then settled and inputs may change.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0;
    rd_start = 0; wr_start = 0; mem_rdata = '0; mem_ack = 0;
    step(); step();
    reset_n = 1'b1;
    step();
    // ---- reset state
    checkVal("rst_mdr",  mdr_q,    32'h0);
    checkVal("rst_addr", {23'd0, mem_addr}, 32'h0);
    checkVal("rst_req",  {31'd0, mem_req},  32'h0);
    checkVal("rst_busy", {31'd0, busy},     32'h0);

    // ---- write path, ack 3 cycles after mem_req rises
    MARin = 1; BusMuxOut = 32'h0000_0205;
    step();
    MARin = 0; MDRin = 1; BusMuxOut = 32'hDEAD_BEEF;
    step();
    MDRin = 0; wr_start = 1; BusMuxOut = 32'h0;
    step();
    wr_start = 0;
    checkVal("wr_req1",   {31'd0, mem_req}, 32'h1);
    checkVal("wr_we",     {31'd0, mem_we},  32'h1);
    checkVal("wr_addr",   {23'd0, mem_addr}, 32'h005);
    checkVal("wr_wdata",  mem_wdata, 32'hDEAD_BEEF);
    step();
    checkVal("wr_req2",   {31'd0, mem_req}, 32'h1);
    step();
    checkVal("wr_req3",   {31'd0, mem_req}, 32'h1);
    checkVal("wr_nodone", {31'd0, done},    32'h0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    checkVal("wr_reqoff", {31'd0, mem_req}, 32'h0);
    checkVal("wr_done",   {31'd0, done},    32'h1);
    checkVal("wr_err",    {31'd0, err},     32'h0);
    step();
    checkVal("wr_done1",  {31'd0, done},    32'h0);
    checkVal("wr_idle",   {31'd0, busy},    32'h0);

    // ---- zero-wait read with MARin alongside rd_start
    MARin = 1; BusMuxOut = 32'h0000_0005; rd_start = 1; mem_rdata = 32'h1234_5678;
    step();
    MARin = 0; rd_start = 0; mem_ack = 1;
    checkVal("rd_addr", {23'd0, mem_addr}, 32'h005);
    checkVal("rd_req",  {31'd0, mem_req},  32'h1);
    checkVal("rd_we",   {31'd0, mem_we},   32'h0);
    step();
    mem_ack = 0;
    checkVal("rd_mdr",  mdr_q, 32'h1234_5678);
    checkVal("rd_done", {31'd0, done}, 32'h1);
    checkVal("rd_err",  {31'd0, err},  32'h0);
    step();
    checkVal("rd_idle", {31'd0, busy}, 32'h0);

    // ---- timeout with no ack
    mem_rdata = 32'hAAAA_AAAA;
    rd_start = 1;
    step();
    rd_start = 0;
    cycles = 0;
    while (mem_req && cycles < 40) begin
      cycles++;
      step();
    end
    checkVal("to_cycles", cycles, 32'd16);
    checkVal("to_done",   {31'd0, done}, 32'h1);
    checkVal("to_err",    {31'd0, err},  32'h1);
    checkVal("to_mdr",    mdr_q, 32'h1234_5678);
    step();
    checkVal("to_done1",  {31'd0, done}, 32'h0);
    checkVal("to_err1",   {31'd0, err},  32'h0);

    // ---- ack exactly on the 16th request cycle wins over timeout
    rd_start = 1;
    step();
    rd_start = 0;
    for (int i = 0; i < 15; i++) step();
    checkVal("ta_req16", {31'd0, mem_req}, 32'h1);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 0;
    checkVal("ta_done", {31'd0, done}, 32'h1);
    checkVal("ta_err",  {31'd0, err},  32'h0);
    checkVal("ta_mdr",  mdr_q, 32'hCAFE_F00D);
    step();

    // ---- loads and starts ignored while busy
    rd_start = 1;
    step();
    rd_start = 0;
    wr_start = 1; MARin = 1; MDRin = 1; BusMuxOut = 32'hFFFF_FFFF;
    step();
    wr_start = 0; MARin = 0; MDRin = 0; BusMuxOut = 32'h0;
    checkVal("ib_addr", {23'd0, mem_addr}, 32'h005);
    checkVal("ib_mdr",  mdr_q, 32'hCAFE_F00D);
    checkVal("ib_we",   {31'd0, mem_we}, 32'h0);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    checkVal("ib_done", {31'd0, done}, 32'h1);
    wr_start = 1;  // start during DONE must be dropped
    step();
    wr_start = 0;
    step();
    checkVal("ib_noreq",  {31'd0, mem_req}, 32'h0);
    checkVal("ib_nobusy", {31'd0, busy},    32'h0);
    checkVal("ib_mdr2",   mdr_q, 32'h0BAD_F00D);

    // ---- ack outside a request is ignored
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 0;
    checkVal("ia_mdr",  mdr_q, 32'h0BAD_F00D);
    checkVal("ia_done", {31'd0, done}, 32'h0);

    // ---- rd_start and wr_start together -> read only
    rd_start = 1; wr_start = 1;
    step();
    rd_start = 0; wr_start = 0;
    checkVal("rw_req", {31'd0, mem_req}, 32'h1);
    checkVal("rw_we",  {31'd0, mem_we},  32'h0);
    mem_ack = 1; mem_rdata = 32'h7777_0001;
    step();
    mem_ack = 0;
    checkVal("rw_mdr", mdr_q, 32'h7777_0001);
    step(); step();
    checkVal("rw_idle", {31'd0, busy}, 32'h0);

    // ---- asynchronous reset in the middle of a write request
    wr_start = 1;
    step();
    wr_start = 0;
    checkVal("ar_req", {31'd0, mem_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkVal("ar_reqoff", {31'd0, mem_req}, 32'h0);
    checkVal("ar_busy",   {31'd0, busy},    32'h0);
    checkVal("ar_mdr",    mdr_q, 32'h0);
    checkVal("ar_addr",   {23'd0, mem_addr}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    checkVal("ar_idle",   {31'd0, busy}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
